gpio_ctrl: RTL and testbench
============================

Name: gpio_ctrl

Overview:
Parametrised memory-mapped GPIO controller and successor to the single-register output port. It decodes a 32-bit bus address against a configurable base and exposes five registers: output data, direction, synchronised input, interrupt enable and interrupt status. It drives pad output and output-enable, samples pad inputs through a synchroniser, and raises a level interrupt on rising input edges. It sits on the processor data bus beside data memory.

Parameters:
WIDTH, 32, number of GPIO pins and register width (1..32)
BASE_ADDR, 32'h0000abcd, address of the DATA_OUT register; the other registers follow at +4 steps
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
a  in  32  bus address
d  in  32  bus write data; bits [WIDTH-1:0] used
we  in  1  write strobe, sampled on CLK
re  in  1  read strobe, sampled on CLK
rdata  out  32  registered read data, zero-extended
gpio_in  in  WIDTH  asynchronous pad inputs
gpio_out  out  WIDTH  pad output values (DATA_OUT)
gpio_oe  out  WIDTH  pad output enables (DIR; 1 = drive)
irq  out  1  interrupt request, active high, level

Behaviour:
- Register map, exact 32-bit compare: BASE+0 DATA_OUT (R/W); BASE+4 DIR (R/W); BASE+8 DATA_IN (RO); BASE+12 IRQ_EN (R/W); BASE+16 IRQ_STAT (R, write-1-to-clear).
- Reset (RST_N low, async): DATA_OUT=0, DIR=0, IRQ_EN=0, IRQ_STAT=0, all synchroniser and edge flops=0, rdata=0. Outputs follow immediately: gpio_out=0, gpio_oe=0, irq=0. Release is synchronous to the next CLK edge.
- Write: when we=1 at a CLK edge with a matching address, the register takes d[WIDTH-1:0] on that edge. gpio_out/gpio_oe show the new value in the following cycle (one-cycle latency, no extra flop).
- Writes to DATA_IN or unmapped addresses are ignored. DATA_OUT holds its value regardless of DIR.
- Read: when re=1 at edge N, rdata holds the addressed register (zero-extended) after edge N. Unmapped address gives rdata=0. When re=0, rdata holds its previous value. When we and re are both set on the same address, rdata returns the old value and the write still takes effect.
- Input path: gpio_in passes through an SYNC_STAGES-deep flop chain; DATA_IN is the last stage. Visible latency is SYNC_STAGES edges.
- Edge detect: one extra flop holds the previous DATA_IN. A rise is DATA_IN & ~prev. Detection is independent of DIR and IRQ_EN.
- IRQ_STAT[i] sets on a rise of pin i and clears on a write with d[i]=1 to BASE+16. Same-cycle set and clear on the same bit: set wins. Bits with d[i]=0 are unaffected.
- irq = |(IRQ_STAT & IRQ_EN), combinational from flops. No glitch path from bus inputs.
- Enabling IRQ_EN over an already-set status bit raises irq in the next cycle.
- Reset mid-operation clears pending status and returns all pins to input.

Decomposition:
- gpio_pkg: register offset constants (OFS_DOUT=0, OFS_DIR=4, OFS_DIN=8, OFS_IEN=12, OFS_IST=16) and the reset-value constant.
- Sub-module gpio_sync (WIDTH, SYNC_STAGES): synchroniser chain plus previous-value flop. Outputs DATA_IN and the rise vector. Instantiated once.

Test Plan:
1. Reset, then write 32'h000000A5 to 32'habcd and 32'h000000FF to 32'habd1 -> next cycle gpio_out=8'hA5 and gpio_oe=8'hFF in the low bits; read of 32'habcd gives rdata=32'h000000A5 one cycle later.
2. Drive gpio_in=32'h00000003 -> DATA_IN (32'habd5) reads 0 until SYNC_STAGES=2 edges have passed, then 32'h00000003.
3. IRQ_EN=32'h1; gpio_in[0] 0->1 -> IRQ_STAT=1 and irq=1 three edges after the change. Write 32'h1 to 32'habdd -> irq=0 next cycle. A rise on gpio_in[1] with IRQ_EN[1]=0 sets IRQ_STAT[1] but irq stays 0.
4. Rise on pin 0 arriving in the same cycle as a W1C of bit 0 -> IRQ_STAT[0] remains 1.
5. Write to 32'habd5 and to 32'h00001000 -> no register changes. Read of 32'h00001000 -> rdata=0.
6. With DATA_OUT=32'hFFFF, DIR=32'hFFFF and IRQ_STAT≠0, pulse RST_N low for less than one clock period mid-cycle -> all outputs go to 0 immediately, without waiting for a CLK edge.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: register map offsets, reset value and address decode shared by the GPIO controller.
package gpio_pkg;

    localparam logic [31:0] OFS_DOUT = 32'd0;
    localparam logic [31:0] OFS_DIR  = 32'd4;
    localparam logic [31:0] OFS_DIN  = 32'd8;
    localparam logic [31:0] OFS_IEN  = 32'd12;
    localparam logic [31:0] OFS_IST  = 32'd16;
    localparam logic [31:0] RST_VAL  = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_DOUT,
        SEL_DIR,
        SEL_DIN,
        SEL_IEN,
        SEL_IST
    } reg_sel_e;

    // Exact 32-bit match; anything else is unmapped.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr, input logic [31:0] base);
        return (addr == base + OFS_DOUT) ? SEL_DOUT :
               (addr == base + OFS_DIR)  ? SEL_DIR  :
               (addr == base + OFS_DIN)  ? SEL_DIN  :
               (addr == base + OFS_IEN)  ? SEL_IEN  :
               (addr == base + OFS_IST)  ? SEL_IST  : SEL_NONE;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: multi-stage pad input synchroniser plus a previous-value flop for rising-edge detection.
module gpio_sync
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] rise
);

    localparam logic [WIDTH-1:0] RST_W = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;

    always_comb begin
        sync_d[0] = gpio_in;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '{default: RST_W};
            prev_q <= RST_W;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign data_in = sync_q[SYNC_STAGES-1];
    assign rise    = data_in & ~prev_q;

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO with output data, direction, synchronised input,
// and a rising-edge interrupt with write-1-to-clear status.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_abcd,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [31:0]      a,
    input  logic [31:0]      d,
    input  logic             we,
    input  logic             re,
    output logic [31:0]      rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [WIDTH-1:0] RST_W = RST_VAL[WIDTH-1:0];

    reg_sel_e         sel;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] ien_q, ien_d;
    logic [WIDTH-1:0] ist_q, ist_d;
    logic [31:0]      rdata_q, rdata_d;

    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (CLK),
        .rst_n   (RST_N),
        .gpio_in (gpio_in),
        .data_in (din),
        .rise    (rise)
    );

    always_comb begin
        sel     = decode_addr(a, BASE_ADDR);
        dout_d  = (we && sel == SEL_DOUT) ? d[WIDTH-1:0] : dout_q;
        dir_d   = (we && sel == SEL_DIR)  ? d[WIDTH-1:0] : dir_q;
        ien_d   = (we && sel == SEL_IEN)  ? d[WIDTH-1:0] : ien_q;
        w1c     = (we && sel == SEL_IST)  ? d[WIDTH-1:0] : '0;
        // A rise in the same cycle as its clear must not be lost.
        ist_d   = (ist_q & ~w1c) | rise;
        rd_val  = (sel == SEL_DOUT) ? dout_q :
                  (sel == SEL_DIR)  ? dir_q  :
                  (sel == SEL_DIN)  ? din    :
                  (sel == SEL_IEN)  ? ien_q  :
                  (sel == SEL_IST)  ? ist_q  : '0;
        rdata_d = re ? 32'(rd_val) : rdata_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dout_q  <= RST_W;
            dir_q   <= RST_W;
            ien_q   <= RST_W;
            ist_q   <= RST_W;
            rdata_q <= RST_VAL;
        end else begin
            dout_q  <= dout_d;
            dir_q   <= dir_d;
            ien_q   <= ien_d;
            ist_q   <= ist_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata    = rdata_q;
    assign gpio_out = dout_q;
    assign gpio_oe  = dir_q;
    assign irq      = |(ist_q & ien_q);

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed register-map scenarios followed by random bus/pad traffic
// checked every cycle against a behavioural register-map model.
module tb_gpio_ctrl;

    localparam int          W = 32;
    localparam int          S = 2;
    localparam logic [31:0] B = 32'h0000_abcd;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [31:0]   a = '0, d = '0;
    logic          we = 1'b0, re = 1'b0;
    logic [31:0]   rdata;
    logic [W-1:0]  gpio_in = '0;
    logic [W-1:0]  gpio_out, gpio_oe;
    logic          irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_dout, m_dir, m_ien, m_ist, m_rdata;
    logic [31:0] m_hist[$];

    always #5 CLK = ~CLK;

    gpio_ctrl #(
        .WIDTH       (W),
        .BASE_ADDR   (B),
        .SYNC_STAGES (S)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .a        (a),
        .d        (d),
        .we       (we),
        .re       (re),
        .rdata    (rdata),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] hist(input int i);
        return (i < m_hist.size()) ? m_hist[i] : 32'h0;
    endfunction

    task automatic m_reset();
        m_dout = '0; m_dir = '0; m_ien = '0; m_ist = '0; m_rdata = '0;
        m_hist.delete();
    endtask

    // Pad value seen by DATA_IN is the one sampled S-1 edges before the most recent edge.
    task automatic m_step();
        logic [31:0] din, prev, clr;
        if (!RST_N) return;
        din  = hist(S-1);
        prev = hist(S);
        if (re)
            m_rdata = (a == B)      ? m_dout :
                      (a == B + 4)  ? m_dir  :
                      (a == B + 8)  ? din    :
                      (a == B + 12) ? m_ien  :
                      (a == B + 16) ? m_ist  : 32'h0;
        clr   = (we && a == B + 16) ? d : 32'h0;
        m_ist = (m_ist & ~clr) | (din & ~prev);
        if (we && a == B)      m_dout = d;
        if (we && a == B + 4)  m_dir  = d;
        if (we && a == B + 12) m_ien  = d;
        m_hist.push_front(gpio_in);
        if (m_hist.size() > S + 1) void'(m_hist.pop_back());
    endtask

    task automatic check_all();
        check("rdata", rdata, m_rdata);
        check("gpio_out", gpio_out, m_dout);
        check("gpio_oe", gpio_oe, m_dir);
        check("irq", {31'h0, irq}, {31'h0, |(m_ist & m_ien)});
    endtask

    task automatic cyc();
        m_step();
        @(posedge CLK);
        @(negedge CLK);
        check_all();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        a = addr; d = data; we = 1'b1; re = 1'b0;
        cyc();
        we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr);
        a = addr; re = 1'b1; we = 1'b0;
        cyc();
        re = 1'b0;
    endtask

    initial begin
        m_reset();
        repeat (3) cyc();
        RST_N = 1'b1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_out", gpio_out, 32'h0);
        check("rst_oe", gpio_oe, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);

        wr(B, 32'h0000_00A5);
        check("t1_out", gpio_out, 32'h0000_00A5);
        wr(B + 4, 32'h0000_00FF);
        check("t1_oe", gpio_oe, 32'h0000_00FF);
        rd(B);
        check("t1_rd", rdata, 32'h0000_00A5);
        a = B; d = 32'h0000_005A; we = 1'b1; re = 1'b1;
        cyc();
        we = 1'b0; re = 1'b0;
        check("t1_rw_old", rdata, 32'h0000_00A5);
        check("t1_rw_new", gpio_out, 32'h0000_005A);
        wr(B, 32'h0000_00A5);

        gpio_in = 32'h3;
        rd(B + 8);
        check("t2_din_e1", rdata, 32'h0);
        rd(B + 8);
        check("t2_din_e2", rdata, 32'h0);
        rd(B + 8);
        check("t2_din_e3", rdata, 32'h3);

        gpio_in = 32'h0;
        repeat (4) cyc();
        wr(B + 16, 32'hFFFF_FFFF);
        wr(B + 12, 32'h1);
        gpio_in = 32'h1;
        cyc();
        cyc();
        check("t3_irq_e2", {31'h0, irq}, 32'h0);
        cyc();
        check("t3_irq_e3", {31'h0, irq}, 32'h1);
        wr(B + 16, 32'h1);
        check("t3_irq_clr", {31'h0, irq}, 32'h0);
        gpio_in = 32'h3;
        repeat (4) cyc();
        rd(B + 16);
        check("t3_ist1", rdata, 32'h2);
        check("t3_irq_masked", {31'h0, irq}, 32'h0);

        gpio_in = 32'h2;
        repeat (4) cyc();
        gpio_in = 32'h3;
        cyc();
        cyc();
        wr(B + 16, 32'h1);
        rd(B + 16);
        check("t4_set_wins", rdata, 32'h3);
        check("t4_irq", {31'h0, irq}, 32'h1);

        wr(B + 8, 32'hFFFF_FFFF);
        wr(32'h0000_1000, 32'hFFFF_FFFF);
        check("t5_out", gpio_out, 32'h0000_00A5);
        check("t5_oe", gpio_oe, 32'h0000_00FF);
        rd(B + 12);
        check("t5_ien", rdata, 32'h1);
        rd(32'h0000_1000);
        check("t5_unmapped", rdata, 32'h0);

        wr(B, 32'h0000_FFFF);
        wr(B + 4, 32'h0000_FFFF);
        rd(B);
        check("t6_pre_irq", {31'h0, irq}, 32'h1);
        #2 RST_N = 1'b0;
        m_reset();
        #1;
        check("t6_out", gpio_out, 32'h0);
        check("t6_oe", gpio_oe, 32'h0);
        check("t6_irq", {31'h0, irq}, 32'h0);
        check("t6_rdata", rdata, 32'h0);
        #1 RST_N = 1'b1;
        cyc();

        for (int i = 0; i < 600; i++) begin
            int r;
            r  = $urandom_range(0, 6);
            a  = (r < 5) ? B + 32'(4 * r) : ((r == 5) ? 32'h0000_1000 : B + 20);
            d  = $urandom;
            we = ($urandom_range(0, 2) == 0);
            re = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) == 0) gpio_in = gpio_in ^ (32'h1 << $urandom_range(0, W - 1));
            if ($urandom_range(0, 40) == 0) gpio_in = $urandom;
            cyc();
        end
        we = 1'b0; re = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
